// File: rtl/nios_adc_cpu_mult_seq.sv
// Sequential multiplier: four half-width partial products through one shared
// HALF_W x HALF_W multiplier, then a sign fix-up, giving MUL/MULH/MULHSU/MULHU.
module nios_adc_cpu_mult_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result
);
    localparam int HALF_W = DATA_W / 2;
    localparam int ACC_W  = 2 * DATA_W;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              neg_q, neg_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [HALF_W-1:0] mul_a, mul_b;
    logic [DATA_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;

    // Unary minus of the most-negative value yields 2^(DATA_W-1), which fits unsigned.
    assign a_neg = ((op == OP_MULH) || (op == OP_MULHSU)) && src1[DATA_W-1];
    assign b_neg = (op == OP_MULH) && src2[DATA_W-1];
    assign a_mag = a_neg ? -src1 : src1;
    assign b_mag = b_neg ? -src2 : src2;

    always_comb begin
        mul_a = a_q[HALF_W-1:0];
        mul_b = b_q[HALF_W-1:0];
        case (state_q)
            PP1:     mul_b = b_q[DATA_W-1:HALF_W];
            PP2:     mul_a = a_q[DATA_W-1:HALF_W];
            PP3: begin
                mul_a = a_q[DATA_W-1:HALF_W];
                mul_b = b_q[DATA_W-1:HALF_W];
            end
            default: ;
        endcase
    end

    assign prod     = DATA_W'(mul_a) * DATA_W'(mul_b);
    assign prod_ext = ACC_W'(prod);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d    = op;
                a_d     = a_mag;
                b_d     = b_mag;
                neg_d   = a_neg ^ b_neg;
                acc_d   = '0;
                state_d = PP0;
            end
            PP0: begin
                acc_d   = prod_ext;
                state_d = PP1;
            end
            PP1: begin
                acc_d   = acc_q + (prod_ext << HALF_W);
                state_d = PP2;
            end
            PP2: begin
                acc_d   = acc_q + (prod_ext << HALF_W);
                state_d = PP3;
            end
            PP3: begin
                acc_d   = acc_q + (prod_ext << DATA_W);
                state_d = FIX;
            end
            FIX: begin
                if (neg_q) acc_d = -acc_q;
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort only cancels work in flight; in IDLE it must not block an accept.
        if (abort && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = !out_valid            ? '0 :
                       (op_q == OP_MUL)      ? acc_q[DATA_W-1:0] :
                                               acc_q[ACC_W-1:DATA_W];

endmodule

// File: tb/tb_nios_adc_cpu_mult_seq.sv
// Directed checks of the sequential multiplier plus a short random sweep
// against a 64-bit reference product.
module tb_nios_adc_cpu_mult_seq;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset, in_valid, abort, out_ready;
    logic [1:0]    op;
    logic [DW-1:0] src1, src2;
    logic          in_ready, out_valid;
    logic [DW-1:0] result;

    int n_chk  = 0;
    int n_fail = 0;

    nios_adc_cpu_mult_seq #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src1(src1), .src2(src2), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_mul(input logic [1:0] o, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (o == 2'b01)               ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Accept edge, then scramble the inputs to show they are not re-sampled.
    task automatic issue(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid = 1'b1; op = o; src1 = a; src2 = b;
        tick();
        in_valid = 1'b0; abort = 1'b0;
        op = 2'($urandom_range(3)); src1 = $urandom; src2 = $urandom;
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [DW-1:0] exp);
        issue(o, a, b);
        repeat (4) tick();
        chk1({tag, ".valid_early"}, out_valid, 1'b0);
        chk({tag, ".result_idle0"}, result, '0);
        tick();
        chk1({tag, ".valid"}, out_valid, 1'b1);
        chk1({tag, ".busy"}, in_ready, 1'b0);
        chk({tag, ".result"}, result, exp);
        tick();
        chk1({tag, ".ready_back"}, in_ready, 1'b1);
        chk1({tag, ".valid_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        op = 2'b00; src1 = '0; src2 = '0;
        repeat (2) tick();
        reset = 1'b0;
        chk1("rst.in_ready", in_ready, 1'b1);
        chk1("rst.out_valid", out_valid, 1'b0);
        chk("rst.result", result, '0);

        run("mul_ffff", 2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001);
        run("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run("mulh_m1x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
        run("mul_m1x2", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
        run("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("mulh_maxpos", 2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF);
        run("mulh_minxmax", 2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000);
        run("mulhsu_min", 2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF);
        run("mulhu_shift", 2'b11, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012);
        run("mul_zero", 2'b00, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000);

        // Abort in IDLE must not block the accept on the same edge.
        abort = 1'b1;
        run("abort_idle", 2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A);

        // Backpressure: DONE holds while out_ready is low.
        out_ready = 1'b0;
        issue(2'b00, 32'h0000_1234, 32'h0000_0010);
        repeat (5) tick();
        for (int i = 0; i < 5; i++) begin
            chk1("bp.valid", out_valid, 1'b1);
            chk1("bp.in_ready", in_ready, 1'b0);
            chk("bp.result", result, 32'h0001_2340);
            tick();
        end
        out_ready = 1'b1;
        chk1("bp.valid_last", out_valid, 1'b1);
        tick();
        chk1("bp.release", in_ready, 1'b1);
        chk1("bp.valid_drop", out_valid, 1'b0);

        // Abort while in PP2.
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_pp2.in_ready", in_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk1("abort_pp2.no_valid", out_valid, 1'b0);
            tick();
        end
        run("after_abort", 2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);

        // Abort together with out_ready in DONE consumes the result.
        issue(2'b00, 32'h0000_0009, 32'h0000_0009);
        repeat (5) tick();
        chk("abort_done.result", result, 32'h0000_0051);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_done.in_ready", in_ready, 1'b1);
        chk1("abort_done.valid", out_valid, 1'b0);

        // Reset in PP3.
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("rst_pp3.in_ready", in_ready, 1'b1);
        chk1("rst_pp3.valid", out_valid, 1'b0);
        chk("rst_pp3.result", result, '0);
        repeat (6) tick();
        chk1("rst_pp3.stays_idle", out_valid, 1'b0);

        // Reset in DONE, with a competing request and abort on the same edge.
        out_ready = 1'b0;
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) tick();
        chk1("rst_done.pre_valid", out_valid, 1'b1);
        reset = 1'b1; in_valid = 1'b1; abort = 1'b1; out_ready = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; abort = 1'b0;
        chk1("rst_done.in_ready", in_ready, 1'b1);
        chk1("rst_done.valid", out_valid, 1'b0);
        chk("rst_done.result", result, '0);
        repeat (6) tick();
        chk1("rst_done.no_accept", out_valid, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [1:0]    ro;
            logic [DW-1:0] ra, rb;
            ro = 2'($urandom_range(3));
            ra = $urandom;
            rb = $urandom;
            if (i % 10 == 0) ra = 32'h8000_0000;
            if (i % 7 == 0)  rb = 32'hFFFF_FFFF;
            run("rand", ro, ra, rb, ref_mul(ro, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nios_adc_cpu_mult_seq.md
NIOS_ADC_CPU_MULT_SEQ -- requirements
Module: nios_adc_cpu_mult_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; must be even, 8..64.
REQ-002 SHALL define HALF_W = DATA_W/2 internally; exactly one HALF_W x HALF_W unsigned multiplier SHALL be instantiated/inferred.
REQ-003 SHALL have one clock and a synchronous, active-high reset:
  clk        in   1       rising-edge clock
  reset      in   1       synchronous reset, active-high
  in_valid   in   1       request valid
  in_ready   out  1       block can accept a request
  op         in   2       00 MUL (low word), 01 MULH (s x s, high), 10 MULHSU (src1 signed x src2 unsigned, high), 11 MULHU (u x u, high)
  src1       in   DATA_W  operand A
  src2       in   DATA_W  operand B
  abort      in   1       cancel in-flight operation
  out_valid  out  1       result valid
  out_ready  in   1       consumer accepts result
  result     out  DATA_W  selected product word

Function
REQ-004 SHALL implement FSM states IDLE, PP0, PP1, PP2, PP3, FIX, DONE; one cycle per state except IDLE/DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-006 On accept SHALL latch op and operand magnitudes |A|,|B| (DATA_W-bit unsigned) and neg = sign(A)^sign(B); operand treated signed only where op says so; MUL treated unsigned (neg=0). Next state PP0.
REQ-007 Magnitude of most-negative value (e.g. 0x8000_0000) SHALL be 2^(DATA_W-1), representable without overflow.
REQ-008 Accumulator SHALL be 2*DATA_W bits: PP0 acc = AL*BL; PP1 acc += (AL*BH)<<HALF_W; PP2 acc += (AH*BL)<<HALF_W; PP3 acc += (AH*BH)<<DATA_W; all additions modulo 2^(2*DATA_W).
REQ-009 FIX SHALL set acc = -acc (two's complement, 2*DATA_W bits) when neg=1, else hold; next state DONE.
REQ-010 In DONE out_valid SHALL be 1; result = acc[DATA_W-1:0] for MUL, acc[2*DATA_W-1:DATA_W] otherwise.
REQ-011 Latency: out_valid SHALL rise exactly 6 cycles after the accepting edge (PP0..FIX = 5 cycles, DONE on 6th).
REQ-012 result and out_valid SHALL remain stable in DONE while out_ready=0, indefinitely.
REQ-013 DONE with out_ready=1 SHALL return to IDLE next cycle; in_ready=1 that cycle. Minimum issue interval 7 cycles; no overlapping operations.
REQ-014 abort=1 in any state other than IDLE SHALL force IDLE next cycle, discard result, out_valid=0 next cycle; abort in IDLE SHALL have no effect and SHALL NOT block an accept the same cycle.
REQ-015 abort and out_ready both 1 in DONE: SHALL go to IDLE; the result counts as consumed.
REQ-016 in_valid/src/op changes after accept SHALL NOT affect the in-flight result.
REQ-017 result SHALL be 0 whenever out_valid=0.

Reset
REQ-018 reset=1 at a rising edge SHALL force IDLE, acc=0, neg=0, op=00, out_valid=0, result=0, in_ready=1 from the following cycle, regardless of state (including mid-operation and DONE).
REQ-019 reset SHALL take priority over accept, abort and out_ready in the same cycle.

Verification (DATA_W=32)
REQ-020 MUL 0x0000_FFFF x 0x0000_FFFF, out_ready=1 -> result 0xFFFE_0001, out_valid exactly 6 cycles after accept, in_ready back 1 cycle later.
REQ-021 MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000; MULH 0xFFFF_FFFF x 0x0000_0002 -> 0xFFFF_FFFF; MUL same operands -> 0xFFFF_FFFE.
REQ-022 MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF; MULHU same operands -> 0xFFFF_FFFE.
REQ-023 Backpressure: out_ready=0 for 5 cycles in DONE -> result/out_valid constant, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-024 abort asserted in PP2 -> IDLE next cycle, out_valid never asserted; next request 3 x 5 (MUL) -> 0x0000_000F.
REQ-025 reset asserted in PP3 and in DONE -> all outputs at REQ-018 values next cycle; random sweep of 10k operands/ops vs. reference model, including DATA_W=8 and 64 builds.
